// File: rtl/mmio_regfile.sv
// ============================================================================
// Module   : mmio_regfile
// Purpose  : PSL MMIO responder for AFU descriptor space and a parametrised
//            problem-state register file, with parity checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_regfile #(
    parameter int          NUM_REGS = 8,
    parameter int          LATENCY  = 2,
    parameter logic [0:63] DESC_00  = 64'h0000000100010010,
    parameter logic [0:63] DESC_08  = 64'h0000000000000001,
    parameter logic [0:63] DESC_0A  = 64'h0000000000000100,
    parameter logic [0:63] DESC_0E  = 64'h0100000000000000
) (
    input  logic                     ha_pclock,
    input  logic                     reset,
    input  logic                     ha_mmval,
    input  logic                     ha_mmcfg,
    input  logic                     ha_mmrnw,
    input  logic                     ha_mmdw,
    input  logic [0:23]              ha_mmad,
    input  logic                     ha_mmadpar,
    input  logic [0:63]              ha_mmdata,
    input  logic                     ha_mmdatapar,
    output logic                     ah_mmack,
    output logic [0:63]              ah_mmdata,
    output logic                     ah_mmdatapar,
    output logic [0:64*NUM_REGS-1]   reg_out,
    output logic [0:NUM_REGS-1]      reg_wr_stb,
    output logic                     parity_err
);

    // ------------------------------------------------------------------
    // Request capture (stage 0): everything the later stages need
    // ------------------------------------------------------------------
    logic        req_val_q,  req_val_d;
    logic        req_cfg_q,  req_cfg_d;
    logic        req_rnw_q,  req_rnw_d;
    logic        req_dw_q,   req_dw_d;
    logic        req_perr_q, req_perr_d;
    logic [0:23] req_ad_q,   req_ad_d;
    logic [0:63] req_data_q, req_data_d;
    logic        parity_err_q, parity_err_d;

    logic        w_addr_bad;
    logic        w_data_bad;

    always_comb begin
        w_addr_bad   = ~(^{ha_mmad, ha_mmadpar});
        w_data_bad   = ~ha_mmrnw & ~(^{ha_mmdata, ha_mmdatapar});
        req_val_d    = ha_mmval;
        req_cfg_d    = ha_mmcfg;
        req_rnw_d    = ha_mmrnw;
        req_dw_d     = ha_mmdw;
        req_ad_d     = ha_mmad;
        req_data_d   = ha_mmdata;
        req_perr_d   = w_addr_bad | w_data_bad;
        parity_err_d = parity_err_q | (ha_mmval & (w_addr_bad | w_data_bad));
    end

    // ------------------------------------------------------------------
    // Register file write and read-data formation (stage 1)
    // ------------------------------------------------------------------
    logic [0:63]         regs_q   [NUM_REGS];
    logic [0:63]         regs_d   [NUM_REGS];
    logic [0:NUM_REGS-1] wr_stb_q, wr_stb_d;

    logic [0:22] w_idx;
    logic [0:23] w_desc_off;
    logic        w_sel_lo;
    logic        w_wr_en;
    logic [0:63] w_reg_rd;
    logic [0:63] w_desc_rd;
    logic [0:63] w_full_rd;
    logic [0:31] w_word_rd;
    logic [0:63] w_rd_data;

    always_comb begin
        w_idx      = req_ad_q[0:22];
        w_desc_off = {req_ad_q[0:22], 1'b0};
        w_sel_lo   = req_ad_q[23];
        w_wr_en    = req_val_q & ~req_rnw_q & ~req_cfg_q & ~req_perr_q;

        // Indices past the end of the file simply match no register.
        w_reg_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]   = regs_q[i];
            wr_stb_d[i] = 1'b0;
            if (w_idx == 23'(i)) begin
                w_reg_rd = regs_q[i];
                if (w_wr_en) begin
                    wr_stb_d[i] = 1'b1;
                    if (req_dw_q) begin
                        regs_d[i] = req_data_q;
                    end else if (w_sel_lo) begin
                        regs_d[i][32:63] = req_data_q[32:63];
                    end else begin
                        regs_d[i][0:31] = req_data_q[32:63];
                    end
                end
            end
        end

        case (w_desc_off)
            24'h000000: w_desc_rd = DESC_00;
            24'h000008: w_desc_rd = DESC_08;
            24'h00000A: w_desc_rd = DESC_0A;
            24'h00000E: w_desc_rd = DESC_0E;
            default:    w_desc_rd = '0;
        endcase

        w_full_rd = req_cfg_q ? w_desc_rd : w_reg_rd;
        w_word_rd = w_sel_lo ? w_full_rd[32:63] : w_full_rd[0:31];

        if (!req_val_q || !req_rnw_q) begin
            w_rd_data = '0;
        end else if (req_perr_q) begin
            w_rd_data = '1;
        end else if (req_dw_q) begin
            w_rd_data = w_full_rd;
        end else begin
            w_rd_data = {w_word_rd, w_word_rd};
        end
    end

    // ------------------------------------------------------------------
    // Response delay line; the last entry drives the PSL outputs
    // ------------------------------------------------------------------
    logic        pipe_val_q  [LATENCY];
    logic        pipe_val_d  [LATENCY];
    logic [0:63] pipe_data_q [LATENCY];
    logic [0:63] pipe_data_d [LATENCY];

    always_comb begin
        pipe_val_d[0]  = req_val_q;
        pipe_data_d[0] = w_rd_data;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_val_d[k]  = pipe_val_q[k-1];
            pipe_data_d[k] = pipe_data_q[k-1];
        end
    end

    always_ff @(posedge ha_pclock or posedge reset) begin
        if (reset) begin
            req_val_q    <= 1'b0;
            req_cfg_q    <= 1'b0;
            req_rnw_q    <= 1'b0;
            req_dw_q     <= 1'b0;
            req_perr_q   <= 1'b0;
            req_ad_q     <= '0;
            req_data_q   <= '0;
            parity_err_q <= 1'b0;
            wr_stb_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            for (int k = 0; k < LATENCY; k++) begin
                pipe_val_q[k]  <= 1'b0;
                pipe_data_q[k] <= '0;
            end
        end else begin
            req_val_q    <= req_val_d;
            req_cfg_q    <= req_cfg_d;
            req_rnw_q    <= req_rnw_d;
            req_dw_q     <= req_dw_d;
            req_perr_q   <= req_perr_d;
            req_ad_q     <= req_ad_d;
            req_data_q   <= req_data_d;
            parity_err_q <= parity_err_d;
            wr_stb_q     <= wr_stb_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            for (int k = 0; k < LATENCY; k++) begin
                pipe_val_q[k]  <= pipe_val_d[k];
                pipe_data_q[k] <= pipe_data_d[k];
            end
        end
    end

    // Parity is formed from the live output so it can never lag the data.
    assign ah_mmack     = pipe_val_q[LATENCY-1];
    assign ah_mmdata    = pipe_data_q[LATENCY-1];
    assign ah_mmdatapar = ~(^ah_mmdata);
    assign reg_wr_stb   = wr_stb_q;
    assign parity_err   = parity_err_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[64*gi +: 64] = regs_q[gi];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mmio_regfile.sv
// ============================================================================
// Module   : tb_mmio_regfile
// Purpose  : Self-checking bench for mmio_regfile (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_regfile;

    localparam int NUM_REGS = 8;
    localparam int LATENCY  = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
    logic [0:23]            ha_mmad;
    logic                   ha_mmadpar;
    logic [0:63]            ha_mmdata;
    logic                   ha_mmdatapar;
    logic                   ah_mmack;
    logic [0:63]            ah_mmdata;
    logic                   ah_mmdatapar;
    logic [0:64*NUM_REGS-1] reg_out;
    logic [0:NUM_REGS-1]    reg_wr_stb;
    logic                   parity_err;

    mmio_regfile #(.NUM_REGS(NUM_REGS), .LATENCY(LATENCY)) dut (
        .ha_pclock   (clk),
        .reset       (reset),
        .ha_mmval    (ha_mmval),
        .ha_mmcfg    (ha_mmcfg),
        .ha_mmrnw    (ha_mmrnw),
        .ha_mmdw     (ha_mmdw),
        .ha_mmad     (ha_mmad),
        .ha_mmadpar  (ha_mmadpar),
        .ha_mmdata   (ha_mmdata),
        .ha_mmdatapar(ha_mmdatapar),
        .ah_mmack    (ah_mmack),
        .ah_mmdata   (ah_mmdata),
        .ah_mmdatapar(ah_mmdatapar),
        .reg_out     (reg_out),
        .reg_wr_stb  (reg_wr_stb),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg;
        logic        rnw;
        logic        dw;
        logic        bad_ad;
        logic        bad_dat;
        logic [0:23] ad;
        logic [0:63] data;
        logic [0:63] exp;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [0:63] data;
        int          cyc;
    } exp_t;

    vec_t tbl[20];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stb_cnt[NUM_REGS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic cfg, input logic rnw, input logic dw,
                                input logic [0:23] ad, input logic [0:63] data,
                                input logic bad_ad, input logic bad_dat,
                                input logic [0:63] exp);
        vec_t v;
        v.cfg = cfg; v.rnw = rnw; v.dw = dw; v.ad = ad; v.data = data;
        v.bad_ad = bad_ad; v.bad_dat = bad_dat; v.exp = exp;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) if (reg_wr_stb[i]) stb_cnt[i]++;
            if (ah_mmack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.chk) chk("rd_data", ah_mmdata, e.data);
                end
            end else begin
                chk("idle_data", ah_mmdata, 64'd0);
            end
            chk("datapar", {63'd0, ah_mmdatapar}, {63'd0, ~(^ah_mmdata)});
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        ha_mmval     = 1'b1;
        ha_mmcfg     = v.cfg;
        ha_mmrnw     = v.rnw;
        ha_mmdw      = v.dw;
        ha_mmad      = v.ad;
        ha_mmadpar   = ~(^v.ad) ^ v.bad_ad;
        ha_mmdata    = v.data;
        ha_mmdatapar = ~(^v.data) ^ v.bad_dat;
        e.chk  = v.rnw;
        e.data = v.exp;
        e.cyc  = cyc + 1 + LATENCY;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ha_mmval = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        idle(2);
    endtask

    logic [0:63] r3;
    logic [0:63] rsel;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) stb_cnt[i] = 0;
        reset = 1'b1; ha_mmval = 1'b0; ha_mmcfg = 1'b0; ha_mmrnw = 1'b0; ha_mmdw = 1'b0;
        ha_mmad = '0; ha_mmadpar = 1'b1; ha_mmdata = '0; ha_mmdatapar = 1'b1;

        tbl[0]  = mk(1, 1, 1, 24'h0,  64'h0, 0, 0, 64'h0000000100010010);
        tbl[1]  = mk(1, 1, 1, 24'h8,  64'h0, 0, 0, 64'h0000000000000001);
        tbl[2]  = mk(1, 1, 1, 24'hB,  64'h0, 0, 0, 64'h0000000000000100);
        tbl[3]  = mk(1, 1, 1, 24'hE,  64'h0, 0, 0, 64'h0100000000000000);
        tbl[4]  = mk(1, 1, 1, 24'h4,  64'h0, 0, 0, 64'h0);
        tbl[5]  = mk(0, 0, 1, 24'h6,  64'hDEADBEEF01234567, 0, 0, 64'h0);
        tbl[6]  = mk(0, 1, 1, 24'h6,  64'h0, 0, 0, 64'hDEADBEEF01234567);
        tbl[7]  = mk(0, 0, 0, 24'h7,  64'h00000000CAFEF00D, 0, 0, 64'h0);
        tbl[8]  = mk(0, 1, 0, 24'h7,  64'h0, 0, 0, 64'hCAFEF00DCAFEF00D);
        tbl[9]  = mk(0, 1, 1, 24'h7,  64'h0, 0, 0, 64'hDEADBEEFCAFEF00D);
        tbl[10] = mk(0, 1, 0, 24'h6,  64'h0, 0, 0, 64'hDEADBEEFDEADBEEF);
        tbl[11] = mk(0, 0, 0, 24'h2,  64'h1111111112345678, 0, 0, 64'h0);
        tbl[12] = mk(0, 1, 1, 24'h2,  64'h0, 0, 0, 64'h1234567800000000);
        tbl[13] = mk(0, 0, 1, 24'h2,  64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0);
        tbl[14] = mk(0, 1, 1, 24'h2,  64'h0, 0, 0, 64'h1234567800000000);
        tbl[15] = mk(0, 1, 1, 24'h2,  64'h0, 1, 0, 64'hFFFFFFFFFFFFFFFF);
        tbl[16] = mk(0, 1, 1, 24'h10, 64'h0, 0, 0, 64'h0);
        tbl[17] = mk(0, 0, 1, 24'h10, 64'h5555555555555555, 0, 0, 64'h0);
        tbl[18] = mk(1, 0, 1, 24'h0,  64'hAAAAAAAAAAAAAAAA, 0, 0, 64'h0);
        tbl[19] = mk(1, 1, 1, 24'h0,  64'h0, 0, 0, 64'h0000000100010010);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", {63'd0, ah_mmack}, 64'd0);
        chk("rst_data", ah_mmdata, 64'd0);
        chk("rst_par", {63'd0, ah_mmdatapar}, 64'd1);
        chk("rst_perr", {63'd0, parity_err}, 64'd0);
        chk("rst_stb", 64'(reg_wr_stb), 64'd0);
        chk("rst_regs", 64'(|reg_out), 64'd0);

        // Single descriptor read, then the rest of the table back-to-back.
        issue(tbl[0]);
        drain();
        for (int i = 1; i < 20; i++) begin
            if (i == 13) begin
                drain();
                chk("perr_clean", {63'd0, parity_err}, 64'd0);
                chk("stb_cnt3", 64'(stb_cnt[3]), 64'd2);
                chk("stb_cnt1", 64'(stb_cnt[1]), 64'd1);
                r3 = reg_out[192:255];
                chk("reg_out3", r3, 64'hDEADBEEFCAFEF00D);
            end
            issue(tbl[i]);
        end
        drain();
        chk("perr_set", {63'd0, parity_err}, 64'd1);
        chk("stb_cnt1_post", 64'(stb_cnt[1]), 64'd1);
        chk("stb_total", 64'(stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3] +
                             stb_cnt[4] + stb_cnt[5] + stb_cnt[6] + stb_cnt[7]), 64'd3);
        rsel = reg_out[64:127];
        chk("reg_out1", rsel, 64'h1234567800000000);

        // Reset one cycle after a request: it must never be acked.
        issue(mk(0, 1, 1, 24'h6, 64'h0, 0, 0, 64'hDEADBEEFCAFEF00D));
        @(posedge clk); #1;
        ha_mmval = 1'b0;
        reset    = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(8);
        chk("post_rst_perr", {63'd0, parity_err}, 64'd0);
        chk("post_rst_regs", 64'(|reg_out), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            issue(mk(0, 1, 1, 24'(2 * i), 64'h0, 0, 0, 64'h0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
